// File: rtl/i2c_buffer_sequencer.sv
// I2C transaction engine on port 2 of the shared I2C buffer.
// It fetches a descriptor from word 0, runs one byte-level I2C transaction, and writes status back to word 0.
module i2c_buffer_sequencer #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        status,
  output logic [ADDR_W-1:0] buf_address,
  output logic              buf_chipselect,
  output logic              buf_write,
  output logic [3:0]        buf_byteenable,
  output logic [31:0]       buf_writedata,
  input  logic [31:0]       buf_readdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_start,
  output logic              cmd_stop,
  output logic              cmd_read,
  output logic              cmd_nack,
  output logic [7:0]        cmd_wdata,
  input  logic              rsp_valid,
  input  logic [7:0]        rsp_rdata,
  input  logic              rsp_nack,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_LATCH  = 4'd2,
    S_ADDR   = 4'd3,
    S_AWAIT  = 4'd4,
    S_RDW    = 4'd5,
    S_RDL    = 4'd6,
    S_SEND   = 4'd7,
    S_SWAIT  = 4'd8,
    S_RECV   = 4'd9,
    S_RWAIT  = 4'd10,
    S_WB     = 4'd11,
    S_STATUS = 4'd12,
    S_DONE   = 4'd13
  } state_t;

  // Longest transfer the data area (words 1..2^ADDR_W-1) can hold, capped at the 8-bit counter range.
  localparam int          MAX_BYTES = 4 * ((1 << ADDR_W) - 1);
  localparam logic [7:0]  LEN_LIMIT = (MAX_BYTES < 255) ? 8'(MAX_BYTES) : 8'd255;

  state_t      state, state_next;
  logic [7:0]  slave_byte;
  logic [7:0]  len_q;
  logic [7:0]  idx;
  logic [31:0] word_q;
  logic [7:0]  rx_q;
  logic [1:0]  nack_q;
  logic        is_last;
  logic [7:0]  len_raw;
  logic [7:0]  status_byte;
  logic [ADDR_W-1:0] data_addr;

  assign len_raw     = buf_readdata[15:8];
  assign is_last     = (idx == len_q - 8'd1);
  assign status_byte = {1'b1, 5'b0, nack_q};
  assign data_addr   = ADDR_W'(idx >> 2) + ADDR_W'(1);
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Command handshake: cmd_valid and every cmd_* field are held steady from the
  // state's first cycle until the cycle where cmd_valid & cmd_ready are both high;
  // the next state drops cmd_valid and waits for rsp_valid, so one command is in flight.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  state_next = S_LATCH;
      S_LATCH:  state_next = S_ADDR;
      S_ADDR:   if (cmd_ready) state_next = S_AWAIT;
      S_AWAIT: begin
        if (rsp_valid) begin
          if (rsp_nack || len_q == 8'd0) state_next = S_STATUS;
          else if (slave_byte[0])        state_next = S_RECV;
          else                           state_next = S_RDW;
        end
      end
      S_RDW:    state_next = S_RDL;
      S_RDL:    state_next = S_SEND;
      S_SEND:   if (cmd_ready) state_next = S_SWAIT;
      S_SWAIT: begin
        if (rsp_valid) begin
          if (rsp_nack || is_last)   state_next = S_STATUS;
          else if (idx[1:0] == 2'd3) state_next = S_RDW;
          else                       state_next = S_SEND;
        end
      end
      S_RECV:   if (cmd_ready) state_next = S_RWAIT;
      S_RWAIT:  if (rsp_valid) state_next = S_WB;
      S_WB:     state_next = is_last ? S_STATUS : S_RECV;
      S_STATUS: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != S_IDLE);
    done           = 1'b0;
    buf_address    = '0;
    buf_chipselect = 1'b0;
    buf_write      = 1'b0;
    buf_byteenable = 4'b0000;
    buf_writedata  = 32'h0;
    cmd_valid      = 1'b0;
    cmd_start      = 1'b0;
    cmd_stop       = 1'b0;
    cmd_read       = 1'b0;
    cmd_nack       = 1'b0;
    cmd_wdata      = 8'h00;
    case (state)
      S_FETCH: begin
        buf_chipselect = 1'b1;
      end
      S_ADDR: begin
        cmd_valid = 1'b1;
        cmd_start = 1'b1;
        cmd_stop  = (len_q == 8'd0);
        cmd_wdata = slave_byte;
      end
      S_RDW: begin
        buf_chipselect = 1'b1;
        buf_address    = data_addr;
      end
      S_SEND: begin
        cmd_valid = 1'b1;
        cmd_stop  = is_last;
        cmd_wdata = 8'(word_q >> {idx[1:0], 3'b000});
      end
      S_RECV: begin
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_nack  = is_last;
        cmd_stop  = is_last;
      end
      S_WB: begin
        buf_chipselect = 1'b1;
        buf_write      = 1'b1;
        buf_address    = data_addr;
        buf_byteenable = 4'b0001 << idx[1:0];
        buf_writedata  = {4{rx_q}};
      end
      S_STATUS: begin
        buf_chipselect = 1'b1;
        buf_write      = 1'b1;
        buf_byteenable = 4'b1000;
        buf_writedata  = {status_byte, 24'h0};
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // The descriptor is captured once in LATCH, so CPU writes to word 0 afterwards have no effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      slave_byte <= 8'h00;
      len_q      <= 8'h00;
      idx        <= 8'h00;
      word_q     <= 32'h0;
      rx_q       <= 8'h00;
      nack_q     <= 2'b00;
      status     <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx    <= 8'h00;
            nack_q <= 2'b00;
          end
        end
        S_LATCH: begin
          slave_byte <= buf_readdata[7:0];
          len_q      <= (len_raw > LEN_LIMIT) ? LEN_LIMIT : len_raw;
        end
        S_AWAIT: if (rsp_valid && rsp_nack) nack_q[0] <= 1'b1;
        S_RDL:   word_q <= buf_readdata;
        S_SWAIT: begin
          if (rsp_valid) begin
            if (rsp_nack) nack_q[1] <= 1'b1;
            else          idx <= idx + 8'd1;
          end
        end
        S_RWAIT:  if (rsp_valid) rx_q <= rsp_rdata;
        S_WB:     idx <= idx + 8'd1;
        S_STATUS: status <= status_byte;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_buffer_sequencer.sv
// Directed bench for i2c_buffer_sequencer: a port-2 buffer model, a scripted PHY, and a command scoreboard.
module tb_i2c_buffer_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [7:0]  status;
  logic [5:0]  buf_address;
  logic        buf_chipselect, buf_write;
  logic [3:0]  buf_byteenable;
  logic [31:0] buf_writedata, buf_readdata;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        cmd_start, cmd_stop, cmd_read, cmd_nack;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_rdata = 8'h00;
  logic        rsp_nack = 1'b0;
  logic [3:0]  dbg_state;

  i2c_buffer_sequencer #(.ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .status(status),
    .buf_address(buf_address), .buf_chipselect(buf_chipselect), .buf_write(buf_write),
    .buf_byteenable(buf_byteenable), .buf_writedata(buf_writedata), .buf_readdata(buf_readdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_read(cmd_read), .cmd_nack(cmd_nack), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- buffer model: port 1 = CPU, port 2 = DUT ----------------
  logic [31:0] mem [0:63];
  logic [5:0]  addr_q;
  logic        cpu_we = 1'b0;
  logic [5:0]  cpu_addr = 6'd0;
  logic [31:0] cpu_wdata = 32'h0;

  always_ff @(posedge clk) begin
    addr_q <= buf_address;
    if (cpu_we) mem[cpu_addr] <= cpu_wdata;
    if (buf_chipselect && buf_write) begin
      for (int b = 0; b < 4; b++)
        if (buf_byteenable[b]) mem[buf_address][8*b +: 8] <= buf_writedata[8*b +: 8];
    end
  end
  assign buf_readdata = mem[addr_q];

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  rd_q[$];
  int          phy_cnt = 0;
  int          nack_at = -1;
  bit          phy_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ent(input bit s, input bit p, input bit r, input bit n,
                                      input logic [7:0] d);
    return {s, p, r, n, d};
  endfunction

  // ---------------- PHY model ----------------
  initial begin : phy
    logic [11:0] seen;
    logic [11:0] cur;
    logic [11:0] want;
    bit          have;
    bit          pend;
    bit          r_nack;
    logic [7:0]  r_data;
    int          wait_n;
    have = 0; pend = 0; r_nack = 0; r_data = 8'h00; wait_n = 0; seen = '0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      cur = {cmd_start, cmd_stop, cmd_read, cmd_nack, cmd_wdata};
      if (reset) begin
        cmd_ready = 1'b0;
        have = 0;
        pend = 0;
      end else if (cmd_ready) begin
        cmd_ready = 1'b0;
        check("valid_drop", {31'b0, cmd_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", {20'b0, seen}, 32'hFFF);
        end else begin
          want = exp_q.pop_front();
          check("cmd_fields", {20'b0, seen}, {20'b0, want});
        end
        if (seen[9]) begin
          r_data = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
          r_nack = 1'b0;
        end else begin
          r_data = 8'h00;
          r_nack = (phy_cnt == nack_at);
        end
        phy_cnt++;
        have = 0;
        pend = 1;
      end else if (pend) begin
        pend = 0;
        rsp_valid = 1'b1;
        rsp_nack  = r_nack;
        rsp_rdata = r_data;
      end else if (cmd_valid && !phy_stall) begin
        if (!have) begin
          have = 1;
          seen = cur;
          wait_n = $urandom_range(0, 2);
        end else begin
          check("cmd_stable", {20'b0, cur}, {20'b0, seen});
        end
        if (wait_n == 0) cmd_ready = 1'b1;
        else wait_n--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  // Returns at the negedge of the first busy cycle (FETCH).
  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input logic [7:0] exp_status);
    int n;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("status", {24'b0, status}, {24'b0, exp_status});
      check("busy_in_done", {31'b0, busy}, 32'd1);
      @(negedge clk);
      check("done_pulse", {31'b0, done}, 32'd0);
      check("idle_after", {31'b0, busy}, 32'd0);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    int base;
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_status", {24'b0, status}, 32'd0);
    check("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    check("rst_cs", {31'b0, buf_chipselect}, 32'd0);
    reset = 1'b0;

    // Write 5 bytes to 0x50, with start-to-command timing checks.
    cpu_write(6'd0, 32'h0000_05A0);
    cpu_write(6'd1, 32'h4433_2211);
    cpu_write(6'd2, 32'h0000_0055);
    exp_q.push_back(ent(1, 0, 0, 0, 8'hA0));
    exp_q.push_back(ent(0, 0, 0, 0, 8'h11));
    exp_q.push_back(ent(0, 0, 0, 0, 8'h22));
    exp_q.push_back(ent(0, 0, 0, 0, 8'h33));
    exp_q.push_back(ent(0, 0, 0, 0, 8'h44));
    exp_q.push_back(ent(0, 1, 0, 0, 8'h55));
    base = phy_cnt;
    pulse_start();
    check("fetch_cs", {31'b0, buf_chipselect}, 32'd1);
    check("fetch_we", {31'b0, buf_write}, 32'd0);
    check("fetch_addr", {26'b0, buf_address}, 32'd0);
    check("fetch_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("latch_cs", {31'b0, buf_chipselect}, 32'd0);
    check("latch_valid", {31'b0, cmd_valid}, 32'd0);
    @(negedge clk);
    check("addr_valid", {31'b0, cmd_valid}, 32'd1);
    check("addr_byte", {24'b0, cmd_wdata}, 32'hA0);
    wait_done(8'h80);
    check("wr5_cmds", phy_cnt - base, 32'd6);
    check("wr5_word0", mem[0], 32'h8000_05A0);

    // Read 3 bytes from 0x50; lane 3 of word 1 must survive.
    cpu_write(6'd0, 32'h0000_03A1);
    cpu_write(6'd1, 32'hDEAD_BEEF);
    rd_q.push_back(8'hAA); rd_q.push_back(8'hBB); rd_q.push_back(8'hCC);
    exp_q.push_back(ent(1, 0, 0, 0, 8'hA1));
    exp_q.push_back(ent(0, 0, 1, 0, 8'h00));
    exp_q.push_back(ent(0, 0, 1, 0, 8'h00));
    exp_q.push_back(ent(0, 1, 1, 1, 8'h00));
    base = phy_cnt;
    pulse_start();
    wait_done(8'h80);
    check("rd3_cmds", phy_cnt - base, 32'd4);
    check("rd3_word1", mem[1], 32'hDECC_BBAA);
    check("rd3_word0", mem[0], 32'h8000_03A1);

    // Address NACK.
    cpu_write(6'd0, 32'h0000_04A0);
    exp_q.push_back(ent(1, 0, 0, 0, 8'hA0));
    base = phy_cnt;
    nack_at = base;
    pulse_start();
    wait_done(8'h81);
    check("anack_cmds", phy_cnt - base, 32'd1);
    check("anack_word0", mem[0], 32'h8100_04A0);

    // Data NACK on the second of four bytes.
    cpu_write(6'd0, 32'h0000_04A0);
    cpu_write(6'd1, 32'h0403_0201);
    exp_q.push_back(ent(1, 0, 0, 0, 8'hA0));
    exp_q.push_back(ent(0, 0, 0, 0, 8'h01));
    exp_q.push_back(ent(0, 0, 0, 0, 8'h02));
    base = phy_cnt;
    nack_at = base + 2;
    pulse_start();
    wait_done(8'h82);
    check("dnack_cmds", phy_cnt - base, 32'd3);
    check("dnack_word0", mem[0], 32'h8200_04A0);
    nack_at = -1;

    // Zero-length probe.
    cpu_write(6'd0, 32'h0000_00A0);
    exp_q.push_back(ent(1, 1, 0, 0, 8'hA0));
    base = phy_cnt;
    pulse_start();
    wait_done(8'h80);
    check("probe_cmds", phy_cnt - base, 32'd1);

    // len=255 clamps to 252; mid-run descriptor overwrite and start pulse must be ignored.
    cpu_write(6'd0, 32'h0000_FFA0);
    for (int k = 1; k < 64; k++)
      cpu_write(6'(k), {8'(4*k-1), 8'(4*k-2), 8'(4*k-3), 8'(4*k-4)});
    exp_q.push_back(ent(1, 0, 0, 0, 8'hA0));
    for (int i = 0; i < 252; i++)
      exp_q.push_back(ent(0, (i == 251), 0, 0, 8'(i)));
    base = phy_cnt;
    pulse_start();
    repeat (6) @(negedge clk);
    cpu_write(6'd0, 32'h0000_0301);
    pulse_start();
    wait_done(8'h80);
    check("clamp_cmds", phy_cnt - base, 32'd253);
    check("clamp_word0", mem[0], 32'h8000_0301);
    repeat (5) @(negedge clk);
    check("no_queued_start", {31'b0, busy}, 32'd0);
    check("exp_q_empty", exp_q.size(), 32'd0);

    // Reset while the address command is stalled, then a clean 2-byte write.
    cpu_write(6'd0, 32'h0000_02A0);
    phy_stall = 1'b1;
    pulse_start();
    n = 0;
    while (!cmd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid", {31'b0, cmd_valid}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", {31'b0, cmd_valid}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_cs", {31'b0, buf_chipselect}, 32'd0);
    check("rst_mid_status", {24'b0, status}, 32'd0);
    reset = 1'b0;
    phy_stall = 1'b0;
    exp_q.push_back(ent(1, 0, 0, 0, 8'hA0));
    exp_q.push_back(ent(0, 0, 0, 0, 8'h00));
    exp_q.push_back(ent(0, 1, 0, 0, 8'h01));
    base = phy_cnt;
    pulse_start();
    wait_done(8'h80);
    check("post_rst_cmds", phy_cnt - base, 32'd3);
    check("post_rst_word0", mem[0], 32'h8000_02A0);
    check("final_exp_q", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_buffer_sequencer.md
# i2c_buffer_sequencer

Transaction engine on the I2C-side port (s2) of the dual-port shared I2C buffer; the CPU owns port s1. After a `start` pulse it fetches a descriptor from buffer word 0 and runs one I2C transaction through the byte-level I2C PHY command interface. Write data is read from the buffer, read data is written back to it, and a status byte is written to word 0 at the end.

## Interface
- `ADDR_W`, 6, buffer word-address width; data area is words 1..2^ADDR_W-1.
- `clk` in 1: sole clock, shared with the buffer.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; ignored unless idle.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at completion.
- `status` out 8: last status byte; held until the next completion.
- `buf_address` out ADDR_W: to `address2`.
- `buf_chipselect`, `buf_write` out 1: to `chipselect2` / `write2`.
- `buf_byteenable` out 4, `buf_writedata` out 32, `buf_readdata` in 32: port-2 data path; `clken2` is tied high at integration.
- `cmd_valid` out 1 / `cmd_ready` in 1: PHY command handshake.
- `cmd_start`, `cmd_stop`, `cmd_read`, `cmd_nack` out 1: generate START before the byte, STOP after it, read instead of write, and master NACK on a read byte.
- `cmd_wdata` out 8: byte to transmit.
- `rsp_valid` in 1, `rsp_rdata` in 8, `rsp_nack` in 1: per-command completion, received byte, and slave NACK on a write byte.

## Operation
- Descriptor (word 0):
  - [7:1] 7-bit slave address; [0] rw (1 = read).
  - [15:8] `len` in bytes. Effective length is min(len, 4·(2^ADDR_W−1), 255), i.e. 252 at default.
  - [31:24] is overwritten with status on completion.
- Byte i lives at word 1+i/4, lane i%4 (lane 0 = bits 7:0).
- States: IDLE → FETCH → LATCH → ADDR → AWAIT, then either the write path or the read path, then STATUS → DONE → IDLE.
  - Write path: loop RDW → RDL → SEND → SWAIT.
  - Read path: loop RECV → RWAIT → WB.
- FETCH: address 0, chipselect 1, write 0.
- LATCH: capture `buf_readdata`. Port-2 read latency is 1 cycle (registered address, unregistered q).
- ADDR: command = {addr,rw}, start=1, read=0, stop=(len==0).
- AWAIT: wait `rsp_valid`.
  - `rsp_nack` → status bit0, go to STATUS. The PHY already issued STOP, because the sequencer sets stop on every terminating byte and the PHY stops on a NACK.
  - len==0 → STATUS.
- Write path:
  - RDW is entered only when i%4==0 and issues a read of word 1+i/4; RDL latches the word.
  - SEND: wdata = lane i%4, stop = (i==len−1).
  - SWAIT: `rsp_nack` on a non-final byte → status bit1, STATUS. A NACK on the final byte also sets bit1.
- Read path:
  - RECV: read=1, nack = stop = (i==len−1).
  - RWAIT: capture `rsp_rdata`.
  - WB: write 1, byteenable = 1<<(i%4), writedata = byte replicated in all 4 lanes, address 1+i/4.
- STATUS: write {status,24'h0}, byteenable 4'b1000, address 0. Status = 0x80 | nack bits.
- DONE: `done`=1 for one cycle; `status` output updates in the same cycle.
- Bus outputs: `buf_chipselect`/`buf_write` are high only in FETCH, RDW, WB and STATUS, and zero otherwise.
- Byte counter is 8 bits and increments after each SWAIT/WB. No wrap is possible because of the clamp.

## Timing
- Reset values:
  - All outputs 0; `cmd_*` 0; `status` 8'h00.
  - A reset mid-transaction returns to IDLE the next cycle and drops `cmd_valid` and `buf_chipselect` immediately. The PHY shares `reset`.
- `start` sampled high in IDLE at cycle 0 → FETCH in cycle 1, LATCH in cycle 2, `cmd_valid` rises in cycle 3.
- Command handshake:
  - `cmd_valid` and all `cmd_*` fields stay stable until the cycle with `cmd_valid & cmd_ready`.
  - `cmd_valid` deasserts the next cycle, and the sequencer then waits for `rsp_valid`.
  - Only one command is outstanding at a time.
- `rsp_valid` outside AWAIT/SWAIT/RWAIT is ignored.
- `start` while busy is ignored; it is not queued.
- CPU writes to word 0 during a transaction do not affect the descriptor, which is latched in LATCH.
- Mixed-port read-during-write is DONT_CARE. The sequencer never reads an address it wrote in the preceding cycle.

## Test plan
- Write of 5 bytes to address 0x50:
  - Stimulus: word0=0x0000_05A0, word1=0x44332211, word2=0x55; PHY always ACKs.
  - Required: commands A0(start), 11, 22, 33, 44, 55(stop); word0[31:24]=0x80; `done` pulse; `status`=0x80.
- Read of 3 bytes from address 0x50:
  - Stimulus: word0=0x0000_03A1; PHY returns AA, BB, CC.
  - Required: the last RECV has nack=stop=1; word1[23:0]=0xCCBBAA; byte lane 3 untouched.
- Address NACK: `rsp_nack` on the address byte → no data commands issued; status 0x81.
- Data NACK on byte 2 of 4 → exactly 3 commands issued; status 0x82.
- Probe and clamp:
  - len=0 → single command with start=stop=1; status 0x80.
  - len=255 → exactly 252 data commands.
- Robustness:
  - `start` pulses during a transaction are ignored.
  - `reset` asserted while waiting for `cmd_ready` → `cmd_valid`=0 and `busy`=0 one cycle later; a fresh `start` then runs normally.
